// File: rtl/hazard_pkg.sv
// Shared constants, stall-cause encoding and the youngest-stage forwarding
// priority helper for the hazard unit.
package hazard_pkg;

  localparam int FWD_RF   = 0;
  localparam int MAX_NFWD = 16;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_LOAD = 2'd1,
    CAUSE_SB   = 2'd2,
    CAUSE_MC   = 2'd3
  } cause_e;

  // Lowest set bit wins (stage 0 is the youngest); returns index+1, or FWD_RF.
  function automatic int youngest_match(input logic [MAX_NFWD-1:0] hits);
    youngest_match = FWD_RF;
    for (int k = MAX_NFWD - 1; k >= 0; k--) begin
      if (hits[k]) youngest_match = k + 1;
    end
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-writeback scoreboard for the single multi-cycle unit: one busy bit
// per architectural register plus a unit-busy flag.
module reg_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          i_set_en,
  input  logic          i_set_rd_en,
  input  logic [AW-1:0] i_set_addr,
  input  logic          i_clr_en,
  input  logic [AW-1:0] i_clr_addr,
  input  logic [AW-1:0] i_look_a,
  input  logic [AW-1:0] i_look_b,
  input  logic [AW-1:0] i_look_c,
  output logic          o_busy_a,
  output logic          o_busy_b,
  output logic          o_busy_c,
  output logic          o_mc_busy
);

  logic [NREG-1:0] r_busy;
  logic            r_mc_busy;

  // NOTE: the busy array is plain flops (not RAM), so it is cleared by reset
  // like any other state; a reset drops every pending writeback.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_busy    <= '0;
      r_mc_busy <= 1'b0;
    end else begin
      // A writeback with no unit pending is stale (e.g. issued before reset).
      if (i_clr_en && r_mc_busy) begin
        r_busy[i_clr_addr] <= 1'b0;
        r_mc_busy          <= 1'b0;
      end
      // NOTE: the set is written after the clear so it wins on the same register.
      if (i_set_en) begin
        r_mc_busy <= 1'b1;
        if (i_set_rd_en && (i_set_addr != '0)) r_busy[i_set_addr] <= 1'b1;
      end
    end
  end

  assign o_busy_a  = r_busy[i_look_a];
  assign o_busy_b  = r_busy[i_look_b];
  assign o_busy_c  = r_busy[i_look_c];
  assign o_mc_busy = r_mc_busy;

endmodule

// File: rtl/hazard_unit_mc.sv
// Data-hazard unit: multi-stage operand/store forwarding, load-use and
// multi-cycle scoreboard stalls, and a saturating stall-cycle counter.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int NFWD = 2,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG),
  parameter int FSW  = $clog2(NFWD + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              id_valid,
  input  logic              flush,
  input  logic [AW-1:0]     id_rs1_addr,
  input  logic [AW-1:0]     id_rs2_addr,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [AW-1:0]     id_rd_addr,
  input  logic              id_regwrite,
  input  logic              id_is_mc,
  input  logic [AW-1:0]     ex_rs1_addr,
  input  logic [AW-1:0]     ex_rs2_addr,
  input  logic              ex_rs1_used,
  input  logic              ex_rs2_used,
  input  logic [AW-1:0]     ex_rd_addr,
  input  logic              ex_regwrite,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [NFWD*AW-1:0] fwd_rd_addr,
  input  logic [NFWD-1:0]   fwd_regwrite,
  input  logic              mc_done,
  input  logic [AW-1:0]     mc_rd_addr,
  output logic              stall,
  output logic [1:0]        stall_cause,
  output logic [FSW-1:0]    fwd_a,
  output logic [FSW-1:0]    fwd_b,
  output logic [FSW-1:0]    fwd_store,
  output logic [31:0]       stall_cycles
);

  logic [MAX_NFWD-1:0] w_hit_a, w_hit_b;
  logic [FSW-1:0]      w_sel_a, w_sel_b;
  logic                w_busy_rs1, w_busy_rs2, w_busy_rd, w_mc_busy;
  logic                w_load_use, w_sb_hit, w_mc_struct;
  logic                w_stall, w_issue;
  cause_e              w_cause;
  logic [31:0]         r_stall_cycles;

  // NOTE: every signal written in always_comb gets a default first, so no latch.
  always_comb begin
    w_hit_a = '0;
    w_hit_b = '0;
    for (int k = 0; k < NFWD; k++) begin
      w_hit_a[k] = fwd_regwrite[k] && (fwd_rd_addr[k*AW +: AW] != '0)
                   && (fwd_rd_addr[k*AW +: AW] == ex_rs1_addr);
      w_hit_b[k] = fwd_regwrite[k] && (fwd_rd_addr[k*AW +: AW] != '0)
                   && (fwd_rd_addr[k*AW +: AW] == ex_rs2_addr);
    end
  end

  assign w_sel_a = FSW'(youngest_match(w_hit_a));
  assign w_sel_b = FSW'(youngest_match(w_hit_b));

  // Store data takes the rs2 forward even when the ALU does not read rs2.
  assign fwd_a     = (RST || !ex_rs1_used) ? FSW'(FWD_RF) : w_sel_a;
  assign fwd_b     = (RST || !ex_rs2_used) ? FSW'(FWD_RF) : w_sel_b;
  assign fwd_store = (RST || !ex_is_store) ? FSW'(FWD_RF) : w_sel_b;

  assign w_load_use = ex_is_load && ex_regwrite && (ex_rd_addr != '0) &&
                      ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                       (id_rs2_used && (id_rs2_addr == ex_rd_addr)));
  assign w_sb_hit    = (id_rs1_used && w_busy_rs1) || (id_rs2_used && w_busy_rs2) ||
                       (id_regwrite && w_busy_rd);
  assign w_mc_struct = id_is_mc && w_mc_busy;

  always_comb begin
    w_cause = CAUSE_NONE;
    if (w_load_use)       w_cause = CAUSE_LOAD;
    else if (w_sb_hit)    w_cause = CAUSE_SB;
    else if (w_mc_struct) w_cause = CAUSE_MC;
    if (RST || flush)     w_cause = CAUSE_NONE;
  end

  assign w_stall     = (w_cause != CAUSE_NONE);
  assign w_issue     = id_valid && !flush && !w_stall;
  assign stall       = w_stall;
  assign stall_cause = w_cause;

  reg_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
    .CLK         (CLK),
    .RST         (RST),
    .i_set_en    (w_issue && id_is_mc),
    .i_set_rd_en (id_regwrite),
    .i_set_addr  (id_rd_addr),
    .i_clr_en    (mc_done),
    .i_clr_addr  (mc_rd_addr),
    .i_look_a    (id_rs1_addr),
    .i_look_b    (id_rs2_addr),
    .i_look_c    (id_rd_addr),
    .o_busy_a    (w_busy_rs1),
    .o_busy_b    (w_busy_rs2),
    .o_busy_c    (w_busy_rd),
    .o_mc_busy   (w_mc_busy)
  );

  always_ff @(posedge CLK) begin
    if (RST)                                      r_stall_cycles <= '0;
    else if (w_stall && (r_stall_cycles != '1))   r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign stall_cycles = r_stall_cycles;

endmodule
